// File: rtl/prover_shim_dot.sv
// rtl/prover_shim_dot.sv - per-copy mod-Q dot product of chi weights and output-layer values
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

module prover_shim_dot #(
   parameter int nCopyBits = 1,
   parameter int nGateBits = 2,
   parameter int nCopies   = 1 << nCopyBits,
   parameter int nGates    = 1 << nGateBits
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   en,
   input  logic [nGates-1:0][`F_NBITS-1:0]         z1_chi,
   input  logic [nCopies*nGates-1:0][`F_NBITS-1:0] vals,
   output logic [nCopies-1:0][`F_NBITS-1:0]        v_z1,
   output logic                                   ready
);

   localparam int FW = `F_NBITS;
   localparam int GW = (nGateBits > 0) ? nGateBits : 1;
   localparam int CW = (nCopyBits > 0) ? nCopyBits : 1;
   localparam int IW = (nCopyBits + nGateBits > 0) ? nCopyBits + nGateBits : 1;
   localparam int BW = (FW > 1) ? $clog2(FW) : 1;
   localparam logic [FW:0] Q_EXT = (FW+1)'(`F_Q);

   // Counts are derived from the bit widths; overriding them independently is a build error.
   if (nCopies != (1 << nCopyBits) || nGates != (1 << nGateBits)) begin : g_bad_param
      $error("prover_shim_dot: nCopies/nGates must not be overridden");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_ACC} state_t;

   state_t                          state_q, state_d;
   logic                            en_dly_q, en_dly_d;
   logic [GW-1:0]                   g_q, g_d;
   logic [CW-1:0]                   c_q, c_d;
   logic [BW-1:0]                   bit_q, bit_d;
   logic [FW-1:0]                   prod_q, prod_d;
   logic [FW-1:0]                   acc_q, acc_d;
   logic [nCopies-1:0][FW-1:0]      v_z1_q, v_z1_d;

   logic [IW-1:0] idx;
   logic          start;
   logic [FW-1:0] a_op, b_op, dbl, acc_new;
   logic          last_g, last_c;

   // Single conditional subtraction is enough because both operands are below Q.
   function automatic logic [FW-1:0] mod_add(input logic [FW-1:0] x, input logic [FW-1:0] y);
      logic [FW:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= Q_EXT) s = s - Q_EXT;
      return s[FW-1:0];
   endfunction

   // Flat operand index c*nGates+g, shaped so degenerate widths stay legal.
   if (nGateBits == 0) begin : g_idx_c
      assign idx = IW'(c_q);
   end else if (nCopyBits == 0) begin : g_idx_g
      assign idx = IW'(g_q);
   end else begin : g_idx_cg
      assign idx = {c_q, g_q};
   end

   // Next-state logic: start detection, bit-serial multiply, accumulate and result capture.
   always_comb begin
      state_d  = state_q;
      en_dly_d = en;
      g_d      = g_q;
      c_d      = c_q;
      bit_d    = bit_q;
      prod_d   = prod_q;
      acc_d    = acc_q;
      v_z1_d   = v_z1_q;

      start   = en & ~en_dly_q;
      ready   = (state_q == ST_IDLE) & ~start;
      a_op    = z1_chi[g_q];
      b_op    = vals[idx];
      dbl     = mod_add(prod_q, prod_q);
      acc_new = mod_add(acc_q, prod_q);
      last_g  = (g_q == GW'(nGates - 1));
      last_c  = (c_q == CW'(nCopies - 1));

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               v_z1_d  = '0;
               acc_d   = '0;
               g_d     = '0;
               c_d     = '0;
               bit_d   = BW'(FW - 1);
               prod_d  = '0;
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            prod_d = b_op[bit_q] ? mod_add(dbl, a_op) : dbl;
            if (bit_q == '0) begin
               state_d = ST_ACC;
            end else begin
               bit_d = bit_q - BW'(1);
            end
         end
         ST_ACC: begin
            if (last_g) begin
               v_z1_d[c_q] = acc_new;
               acc_d       = '0;
               g_d         = '0;
               c_d         = c_q + CW'(1);
            end else begin
               acc_d = acc_new;
               g_d   = g_q + GW'(1);
            end
            bit_d   = BW'(FW - 1);
            prod_d  = '0;
            state_d = (last_g && last_c) ? ST_IDLE : ST_MUL;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; en_dly resets high so a level held through reset is not a start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         en_dly_q <= 1'b1;
         g_q      <= '0;
         c_q      <= '0;
         bit_q    <= '0;
         prod_q   <= '0;
         acc_q    <= '0;
         v_z1_q   <= '0;
      end else begin
         state_q  <= state_d;
         en_dly_q <= en_dly_d;
         g_q      <= g_d;
         c_q      <= c_d;
         bit_q    <= bit_d;
         prod_q   <= prod_d;
         acc_q    <= acc_d;
         v_z1_q   <= v_z1_d;
      end
   end

   assign v_z1 = v_z1_q;

endmodule
